// File: rtl/mips_pkg.sv
// Shared definitions for the fetch unit: state encoding, instruction field
// positions and small address helpers.
package mips_pkg;

    // Fetch state machine encoding; 2'd3 is unused and recovers to RST.
    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Instruction field positions.
    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned JIDX_MSB  = 25;
    localparam int unsigned JIDX_LSB  = 0;

    // Sequential instruction stride in bytes.
    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [5:0] instr_op(input logic [31:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [5:0] instr_funct(input logic [31:0] w);
        return w[FUNCT_MSB:FUNCT_LSB];
    endfunction

    // Clear the byte-offset bits so every PC is a word address.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port between the fetch unit and memory.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection for a retiring instruction: jump, then branch, then
// sequential. Purely combinational.
module next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pcplus4_i,
    input  logic [25:0] jidx_i,
    input  logic        pcsrc_i,
    input  logic        jump_i,
    input  logic [31:0] signimm_i,
    output logic [31:0] npc_o
);

    logic [31:0] btarget;

    // Priority select of the next fetch address, always word aligned.
    always_comb begin
        btarget = pcplus4_i + (signimm_i << 2);
        if (jump_i) begin
            npc_o = {pcplus4_i[31:28], jidx_i, 2'b00};
        end else if (pcsrc_i) begin
            npc_o = word_align(btarget);
        end else begin
            npc_o = word_align(pcplus4_i);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word from instruction memory, holds it
// for the datapath until it retires, then fetches from the selected next PC.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter bit          SIMULTANEOUS_FWD = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pcplus4,
    input  logic               advance,
    input  logic               pcsrc,
    input  logic               jump,
    input  logic [31:0]        signimm,
    output logic [31:0]        retired
);

    localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  retired_q, retired_d;
    logic         first_q, first_d;
    logic [31:0]  npc;
    logic         accept;

    // The PC register is both the fetch address and the held instruction's
    // address: it only moves when the held instruction retires.
    assign pc             = pc_q;
    assign pcplus4        = pc_q + PC_STEP;
    assign instr          = instr_q;
    assign retired        = retired_q;
    assign imem.imem_addr = pc_q;

    // first_q marks the first FETCH cycle, where ready is ignored unless
    // same-cycle forwarding is enabled.
    assign accept = (state_q == FETCH) && imem.imem_ready &&
                    (SIMULTANEOUS_FWD || !first_q);

    next_pc u_next_pc (
        .pcplus4_i (pcplus4),
        .jidx_i    (instr_q[JIDX_MSB:JIDX_LSB]),
        .pcsrc_i   (pcsrc),
        .jump_i    (jump),
        .signimm_i (signimm),
        .npc_o     (npc)
    );

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RST;
            pc_q      <= RESET_PC_ALIGNED;
            instr_q   <= '0;
            retired_q <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            first_q   <= first_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        retired_d      = retired_q;
        first_d        = 1'b0;
        imem.imem_req  = 1'b0;
        instr_valid    = 1'b0;
        case (state_q)
            RST: begin
                state_d = FETCH;
                first_d = 1'b1;
            end
            FETCH: begin
                imem.imem_req = 1'b1;
                if (accept) begin
                    instr_d = imem.imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (advance) begin
                    pc_d      = npc;
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
                    first_d   = 1'b1;
                end
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance, pcsrc, jump;
    logic [31:0] signimm;
    logic [31:0] instr, pc, pcplus4, retired;
    logic        instr_valid;
    logic [31:0] instr2, pc2, pcplus42, retired2;
    logic        instr_valid2;

    int total = 0;
    int bad   = 0;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .advance     (advance),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .signimm     (signimm),
        .retired     (retired)
    );

    fetch_unit #(.RESET_PC(32'h0000_0013), .SIMULTANEOUS_FWD(1'b0)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus2.master),
        .instr       (instr2),
        .instr_valid (instr_valid2),
        .pc          (pc2),
        .pcplus4     (pcplus42),
        .advance     (advance),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .signimm     (signimm),
        .retired     (retired2)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 00000000", pc); end
        total++; if (pcplus4 !== 32'h4) begin bad++; $display("FAIL rst_pcplus4: got %h want 00000004", pcplus4); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 00000000", instr); end
        total++; if (retired !== 32'h0) begin bad++; $display("FAIL rst_retired: got %h want 00000000", retired); end
        total++; if (pc2 !== 32'h10) begin bad++; $display("FAIL rst_pc2_align: got %h want 00000010", pc2); end
        total++; if (pcplus42 !== 32'h14) begin bad++; $display("FAIL rst_pcplus4_2: got %h want 00000014", pcplus42); end
        cyc(); cyc();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req_held: got %b want 0", bus.imem_req); end
    endtask

    task automatic test_tied_ready();
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'hAAAA_0001;
        reset = 1'b0;
        cyc();
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL tied_req: got %b want 1", bus.imem_req); end
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL tied_addr: got %h want 00000000", bus.imem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL tied_valid0: got %b want 0", instr_valid); end
        cyc();
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL tied_valid1: got %b want 1", instr_valid); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL tied_pc: got %h want 00000000", pc); end
        total++; if (instr !== 32'hAAAA_0001) begin bad++; $display("FAIL tied_instr: got %h want aaaa0001", instr); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL tied_req_hold: got %b want 0", bus.imem_req); end
        // ready stays high in HOLD with new data: must be ignored
        bus.imem_rdata = 32'hBAD0_0000;
        cyc(); cyc();
        total++; if (instr !== 32'hAAAA_0001) begin bad++; $display("FAIL hold_ignore_ready: got %h want aaaa0001", instr); end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL hold_valid: got %b want 1", instr_valid); end
        // branch 0x4 + (3<<2) = 0x10
        advance = 1'b1; pcsrc = 1'b1; signimm = 32'd3; bus.imem_ready = 1'b0;
        cyc();
        total++; if (bus.imem_addr !== 32'h10) begin bad++; $display("FAIL br_fwd_addr: got %h want 00000010", bus.imem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL adv_valid_drop: got %b want 0", instr_valid); end
        total++; if (retired !== 32'd1) begin bad++; $display("FAIL adv_retired1: got %h want 00000001", retired); end
        pcsrc = 1'b0; signimm = 32'h0;
    endtask

    task automatic test_delayed_ready();
        // advance and jump held high during FETCH: must be ignored
        advance = 1'b1; jump = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL dly_req c%0d: got %b want 1", i, bus.imem_req); end
            total++; if (bus.imem_addr !== 32'h10) begin bad++; $display("FAIL dly_addr c%0d: got %h want 00000010", i, bus.imem_addr); end
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL dly_valid c%0d: got %b want 0", i, instr_valid); end
            if (i == 4) begin bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1234_5678; end
            cyc();
        end
        advance = 1'b0; jump = 1'b0; bus.imem_ready = 1'b0;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL dly_valid_rise: got %b want 1", instr_valid); end
        total++; if (instr !== 32'h1234_5678) begin bad++; $display("FAIL dly_instr: got %h want 12345678", instr); end
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL dly_pc: got %h want 00000010", pc); end
        total++; if (retired !== 32'd1) begin bad++; $display("FAIL dly_retired: got %h want 00000001", retired); end
        cyc();
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL dly_valid_stay: got %b want 1", instr_valid); end
    endtask

    task automatic test_branch_back();
        advance = 1'b1; pcsrc = 1'b1; signimm = 32'hFFFF_FFFE;
        cyc();
        total++; if (bus.imem_addr !== 32'h0C) begin bad++; $display("FAIL brb_addr: got %h want 0000000c", bus.imem_addr); end
        total++; if (retired !== 32'd2) begin bad++; $display("FAIL brb_retired: got %h want 00000002", retired); end
        advance = 1'b0; pcsrc = 1'b0; signimm = 32'h0;
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0000_0C0C;
        cyc();
        bus.imem_ready = 1'b0;
        total++; if (pc !== 32'h0C) begin bad++; $display("FAIL brb_pc: got %h want 0000000c", pc); end
    endtask

    task automatic test_jump_priority();
        // far branch 0x10 + (0x0FFFFFFC<<2) = 0x40000000
        advance = 1'b1; pcsrc = 1'b1; signimm = 32'h0FFF_FFFC;
        cyc();
        total++; if (bus.imem_addr !== 32'h4000_0000) begin bad++; $display("FAIL far_addr: got %h want 40000000", bus.imem_addr); end
        advance = 1'b0; pcsrc = 1'b0; signimm = 32'h0;
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0800_0040;
        cyc();
        bus.imem_ready = 1'b0;
        total++; if (instr !== 32'h0800_0040) begin bad++; $display("FAIL jmp_instr: got %h want 08000040", instr); end
        advance = 1'b1; jump = 1'b1; pcsrc = 1'b1; signimm = 32'd5;
        cyc();
        total++; if (bus.imem_addr !== 32'h4000_0100) begin bad++; $display("FAIL jmp_addr: got %h want 40000100", bus.imem_addr); end
        total++; if (retired !== 32'd4) begin bad++; $display("FAIL jmp_retired: got %h want 00000004", retired); end
        advance = 1'b0; jump = 1'b0; pcsrc = 1'b0; signimm = 32'h0;
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDDDD_0004;
        cyc();
        bus.imem_ready = 1'b0;
        total++; if (pc !== 32'h4000_0100) begin bad++; $display("FAIL jmp_pc: got %h want 40000100", pc); end
    endtask

    task automatic test_wrap();
        // 0x40000104 + (0x2FFFFFBE<<2) = 0xFFFFFFFC
        advance = 1'b1; pcsrc = 1'b1; signimm = 32'h2FFF_FFBE;
        cyc();
        total++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL top_addr: got %h want fffffffc", bus.imem_addr); end
        total++; if (retired !== 32'd5) begin bad++; $display("FAIL top_retired: got %h want 00000005", retired); end
        advance = 1'b0; pcsrc = 1'b0; signimm = 32'h0;
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'hEEEE_0005;
        cyc();
        bus.imem_ready = 1'b0;
        total++; if (pcplus4 !== 32'h0) begin bad++; $display("FAIL top_pcplus4: got %h want 00000000", pcplus4); end
        advance = 1'b1;
        cyc();
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h want 00000000", bus.imem_addr); end
        total++; if (retired !== 32'd6) begin bad++; $display("FAIL wrap_retired: got %h want 00000006", retired); end
        advance = 1'b0;
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0000_0006;
        cyc();
        bus.imem_ready = 1'b0; advance = 1'b1;
        cyc();
        advance = 1'b0;
        total++; if (bus.imem_addr !== 32'h4) begin bad++; $display("FAIL seq_addr: got %h want 00000004", bus.imem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL mid_req_pre: got %b want 1", bus.imem_req); end
        reset = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL mid_req_drop: got %b want 0", bus.imem_req); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL mid_pc: got %h want 00000000", pc); end
        total++; if (retired !== 32'h0) begin bad++; $display("FAIL mid_retired: got %h want 00000000", retired); end
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'hF00D_F00D;
        cyc(); cyc();
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL mid_no_capture: got %h want 00000000", instr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", instr_valid); end
        reset = 1'b0; bus.imem_ready = 1'b0;
        cyc();
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rst_restart_req: got %b want 1", bus.imem_req); end
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_restart_addr: got %h want 00000000", bus.imem_addr); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_restart_instr: got %h want 00000000", instr); end
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'h600D_0000;
        cyc();
        bus.imem_ready = 1'b0;
        total++; if (instr !== 32'h600D_0000) begin bad++; $display("FAIL rst_restart_cap: got %h want 600d0000", instr); end
        total++; if (retired !== 32'h0) begin bad++; $display("FAIL rst_restart_retired: got %h want 00000000", retired); end
    endtask

    task automatic test_no_fwd();
        reset = 1'b1;
        cyc();
        reset = 1'b0; bus2.imem_ready = 1'b1; bus2.imem_rdata = 32'h2222_0002;
        cyc();
        total++; if (bus2.imem_req !== 1'b1) begin bad++; $display("FAIL nofwd_req: got %b want 1", bus2.imem_req); end
        total++; if (bus2.imem_addr !== 32'h10) begin bad++; $display("FAIL nofwd_addr: got %h want 00000010", bus2.imem_addr); end
        cyc();
        total++; if (instr_valid2 !== 1'b0) begin bad++; $display("FAIL nofwd_first_ignored: got %b want 0", instr_valid2); end
        cyc();
        bus2.imem_ready = 1'b0;
        total++; if (instr_valid2 !== 1'b1) begin bad++; $display("FAIL nofwd_valid: got %b want 1", instr_valid2); end
        total++; if (instr2 !== 32'h2222_0002) begin bad++; $display("FAIL nofwd_instr: got %h want 22220002", instr2); end
        total++; if (instr_op(instr2) !== 6'h08) begin bad++; $display("FAIL nofwd_op: got %h want 08", instr_op(instr2)); end
    endtask

    initial begin
        reset = 1'b1; advance = 1'b0; pcsrc = 1'b0; jump = 1'b0; signimm = 32'h0;
        bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
        bus2.imem_ready = 1'b0; bus2.imem_rdata = 32'h0;
        test_reset();
        test_tied_ready();
        test_delayed_ready();
        test_branch_back();
        test_jump_priority();
        test_wrap();
        test_reset_mid_fetch();
        test_no_fwd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
